// File: rtl/imem_fetch_pkg.sv
// Shared constants and the default fetch-queue entry layout for the instruction fetch path.
package imem_fetch_pkg;

    localparam int unsigned INSTR_WIDTH           = 32;
    localparam int unsigned PC_STEP               = 4;
    localparam int unsigned DEFAULT_ADDRESS_WIDTH = 12;

    // Modules with a non-default ADDRESS_WIDTH declare a same-shaped local struct
    // and hand it to fetch_queue through its entry_t type parameter.
    typedef struct packed {
        logic [DEFAULT_ADDRESS_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0]           instr;
    } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries; flush wins over push and pop.
module fetch_queue
    import imem_fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = fetch_entry_t,
    localparam int unsigned PTR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  entry_t           push_data_i,
    output logic [CNT_W-1:0] count_o,
    output entry_t           head_o
);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             hold_q, hold_d;
    logic               do_push, do_pop;
    logic               not_empty, has_room;

    always_comb begin
        not_empty = (count_q != '0);
        do_pop    = pop_i & ~flush_i & not_empty;
        has_room  = (count_q < CNT_W'(DEPTH)) | do_pop;
        do_push   = push_i & ~flush_i & has_room;

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        hold_d    = hold_q;

        // Shadow of the current head so the outputs keep their last value once empty.
        if (not_empty) begin
            hold_d = mem_q[rd_ptr_q];
        end

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = not_empty ? mem_q[rd_ptr_q] : hold_q;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, queues ROM words, and flushes/refetches on redirect.
module imem_fetch_ctrl
    import imem_fetch_pkg::*;
#(
    parameter int unsigned              ADDRESS_WIDTH = 12,
    parameter int unsigned              DEPTH         = 2,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [INSTR_WIDTH-1:0]   rom_instr,
    input  logic                     fetch_en,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    input  logic                     out_ready,
    output logic                     misalign_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0]   instr;
    } entry_t;

    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic                     misalign_q, misalign_d;
    logic [CNT_W-1:0]         count;
    entry_t                   head;
    entry_t                   push_entry;
    logic                     pop, push;

    always_comb begin
        out_valid  = (count != '0);
        pop        = out_valid & out_ready;
        push       = fetch_en & ~redirect_valid & ((count < CNT_W'(DEPTH)) | pop);

        push_entry = '{pc: fetch_pc_q, instr: rom_instr};

        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(PC_STEP);
        end

        misalign_d = redirect_valid & (|redirect_pc[1:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            misalign_q <= misalign_d;
        end
    end

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .push_data_i (push_entry),
        .count_o     (count),
        .head_o      (head)
    );

    assign rom_addr     = fetch_pc_q;
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed and randomized checks of imem_fetch_ctrl against a queue-based reference model.
module tb_imem_fetch_ctrl;

    localparam int unsigned    AW       = 12;
    localparam int unsigned    DEPTH    = 2;
    localparam logic [AW-1:0]  RESET_PC = '0;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_instr;
    logic          fetch_en;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic [31:0]   out_instr;
    logic [AW-1:0] out_pc;
    logic          out_ready;
    logic          misalign_err;

    logic [31:0] rom [0:1023];
    assign rom_instr = rom[rom_addr[AW-1:2]];

    always #5 clk = ~clk;

    imem_fetch_ctrl #(
        .ADDRESS_WIDTH (AW),
        .DEPTH         (DEPTH),
        .RESET_PC      (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_instr      (rom_instr),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .misalign_err   (misalign_err)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
    } ent_t;

    ent_t          mq [$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] last_pc;
    logic [31:0]   last_instr;
    logic          m_mis;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit   pop;
        bit   push;
        ent_t e;
        if (mq.size() != 0) begin
            last_pc    = mq[0].pc;
            last_instr = mq[0].instr;
        end
        if (rst) begin
            mq.delete();
            m_pc       = RESET_PC;
            last_pc    = '0;
            last_instr = '0;
            m_mis      = 1'b0;
            return;
        end
        pop   = (mq.size() != 0) && out_ready;
        m_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);
        if (redirect_valid) begin
            mq.delete();
            m_pc = {redirect_pc[AW-1:2], 2'b00};
            return;
        end
        push = fetch_en && ((mq.size() < DEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
            e.pc    = m_pc;
            e.instr = rom[m_pc[AW-1:2]];
            mq.push_back(e);
            m_pc = m_pc + AW'(4);
        end
    endtask

    task automatic check_outputs();
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_pc", 32'(out_pc), 32'(mq[0].pc));
            chk("out_instr", out_instr, mq[0].instr);
        end else begin
            chk("out_pc_hold", 32'(out_pc), 32'(last_pc));
            chk("out_instr_hold", out_instr, last_instr);
        end
        chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    endtask

    task automatic step(input bit r, input bit en, input bit rv,
                        input logic [AW-1:0] rp, input bit rdy);
        rst            = r;
        fetch_en       = en;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 32'(i * 4);

        // Reset, then free-running stream from RESET_PC
        step(1, 1, 0, '0, 1);
        step(1, 1, 0, '0, 1);
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_pc", 32'(out_pc), 32'd0);
        repeat (8) step(0, 1, 0, '0, 1);

        // Backpressure from a fresh start: PC must stop at 8 with head held at 0
        step(1, 1, 0, '0, 1);
        repeat (5) step(0, 1, 0, '0, 0);
        chk("bp_rom_addr", 32'(rom_addr), 32'h8);
        chk("bp_head_pc", 32'(out_pc), 32'h0);
        repeat (4) step(0, 1, 0, '0, 1);

        // Redirect while a pop is happening
        chk("redir_pre_valid", 32'(out_valid), 32'd1);
        step(0, 1, 1, 12'h100, 1);
        chk("redir_valid_low", 32'(out_valid), 32'd0);
        chk("redir_rom_addr", 32'(rom_addr), 32'h100);
        step(0, 1, 0, '0, 1);
        chk("redir_first_pc", 32'(out_pc), 32'h100);
        repeat (2) step(0, 1, 0, '0, 1);

        // Misaligned redirect: one-cycle pulse, aligned target
        step(0, 1, 1, 12'h102, 1);
        chk("misalign_pulse", 32'(misalign_err), 32'd1);
        step(0, 1, 0, '0, 1);
        chk("misalign_clear", 32'(misalign_err), 32'd0);
        chk("misalign_pc", 32'(out_pc), 32'h100);
        step(0, 1, 0, '0, 1);

        // Wrap-around at the top of the address space
        step(0, 1, 1, 12'hFFC, 1);
        step(0, 1, 0, '0, 1);
        chk("wrap_pc0", 32'(out_pc), 32'hFFC);
        step(0, 1, 0, '0, 1);
        chk("wrap_pc1", 32'(out_pc), 32'h000);
        step(0, 1, 0, '0, 1);

        // Redirect while full, then fetch_en low drains the queue with PC held
        repeat (3) step(0, 1, 0, '0, 0);
        step(0, 1, 1, 12'h200, 0);
        repeat (2) step(0, 1, 0, '0, 0);
        repeat (4) step(0, 0, 0, '0, 1);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Reset mid-stream
        repeat (3) step(0, 1, 0, '0, 1);
        step(1, 1, 1, 12'h300, 1);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        repeat (3) step(0, 1, 0, '0, 1);

        // Randomized traffic with a randomized ROM image
        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 4) != 0,
                 $urandom_range(0, 9) == 0,
                 AW'($urandom),
                 $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

- Sequences instruction fetch from the byte-addressed, asynchronously read instruction ROM.
- Owns the fetch PC, drives the ROM address, and captures each returned 32-bit word with its PC into a small queue.
- Hands instructions to decode over a valid/ready handshake and handles control-flow redirects by flushing and refetching.
- Sits between the ROM and the decode stage; the ROM itself is unchanged.

## Interface
Parameters:
- ADDRESS_WIDTH, 12, ROM byte-address width; all PCs are this width.
- DEPTH, 2, fetch-queue entries; power of two, ≥ 2.
- RESET_PC, 0, first fetch address after reset; must be word-aligned.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- rom_addr  output  ADDRESS_WIDTH  byte address to the ROM; always equals fetch_pc.
- rom_instr  input  32  combinational ROM word for rom_addr.
- fetch_en  input  1  when low, no new fetches are pushed; the queue still drains.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_pc  input  ADDRESS_WIDTH  redirect target.
- out_valid  output  1  queue head is valid.
- out_instr  output  32  instruction at the queue head.
- out_pc  output  ADDRESS_WIDTH  PC of out_instr.
- out_ready  input  1  decode accepts the head this cycle.
- misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] was nonzero.

## Operation
Reset (rst high at an edge):
- fetch_pc = RESET_PC; queue empty (count = 0).
- out_valid = 0, out_instr = 0, out_pc = 0, misalign_err = 0.

Each cycle:
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < DEPTH | pop).

On push:
- Enqueue {fetch_pc, rom_instr}.
- fetch_pc ← fetch_pc + 4, modulo 2^ADDRESS_WIDTH, so 2^AW−4 wraps to 0.

On pop:
- Dequeue the head.
- Push and pop may occur together when full; count is unchanged.

On redirect_valid:
- Takes priority over push and pop; a simultaneous pop is discarded.
- Queue flushed (count = 0).
- fetch_pc ← {redirect_pc[AW-1:2], 2'b00}.
- misalign_err = |redirect_pc[1:0] on the next cycle only.

Other rules:
- rst overrides everything, including redirect.
- out_instr and out_pc reflect the queue head; they hold their last value while out_valid = 0.
- When fetch_en = 0, fetch_pc holds and queued entries still drain.
- No state other than fetch_pc, the queue, and misalign_err.

## Timing
- C0 = first cycle with rst low: rom_addr = RESET_PC; out_valid = 1 in C1 with out_pc = RESET_PC.
- Fetch-to-output latency is 1 cycle; there is no combinational rom_instr → out_instr path.
- Sustained throughput is 1 instruction/cycle with out_ready and fetch_en held high.
- Redirect asserted in cycle N:
  - out_valid = 0 in N+1.
  - rom_addr = target in N+1.
  - Target instruction valid in N+2.
- Backpressure: with out_ready = 0, the queue fills in DEPTH cycles, then push = 0 and fetch_pc holds.
- Once out_valid = 1, out_instr and out_pc are held stable until pop or redirect.
- Redirect while full: flushed in the same edge; no entry survives.
- rst asserted mid-stream: at that edge, all state returns to reset values.

## Structure
- Package imem_fetch_pkg holds:
  - INSTR_WIDTH = 32.
  - PC_STEP = 4.
  - typedef fetch_entry_t {pc, instr}, parameterised via ADDRESS_WIDTH.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t.
  - DEPTH entries.
  - Inputs push, pop, flush.
  - Outputs count, head.
  - flush has priority over push and pop.
- imem_fetch_ctrl contains only the fetch_pc register, the push/pop/redirect logic, and the misalign_err flop.

## Test plan
- Reset then stream:
  - rst 2 cycles, out_ready = 1, ROM word at addr k = k.
  - Response: out_pc 0, 4, 8, … on consecutive cycles from C1; out_instr matches ROM.
- Backpressure, DEPTH = 2:
  - out_ready = 0 for 5 cycles.
  - Response: fetch_pc stops at 8; out_pc holds 0; after release, 0, 4, 8 appear with no gaps or duplicates.
- Redirect during pop:
  - redirect_valid with redirect_pc = 0x100 while out_valid & out_ready.
  - Response: head consumed by decode is ignored; out_valid = 0 next cycle; then out_pc = 0x100, 0x104.
- Misaligned redirect:
  - redirect_pc = 0x102.
  - Response: misalign_err high for exactly 1 cycle; next out_pc = 0x100.
- Wrap-around:
  - redirect_pc = 0xFFC.
  - Response: out_pc 0xFFC, then 0x000.
- fetch_en low, then reset mid-stream:
  - fetch_en low: queue drains, fetch_pc holds.
  - rst pulse: out_valid = 0 next cycle, then stream restarts at RESET_PC.
